// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central hazard and sequencing controller for a 5-stage MIPS pipeline.
//
// Responsibilities:
//   * Generates the stall, flush and bubble controls for the IF/ID, ID/EX,
//     EX/MEM and MEM/WB pipeline registers.
//   * Generates the EX-stage operand forwarding selects.
//   * Runs a small data-memory wait FSM (IDLE / WAIT / ERROR). The FSM freezes
//     the pipe while a load/store sitting in MEM is waiting on dmem_ready.
//     A wait that lasts too long moves the FSM to a sticky ERROR state.
//
// Action priority, highest first:
//   mem_wait  > branch_taken > load-use
//
// Parameters:
//   MEM_TIMEOUT  Maximum number of WAIT cycles before ERROR (must be >= 1).
//   CNT_W        Width of the performance counters.
//
// Optional feature (compile-time macro PERF_COUNTERS_EN):
//   When defined, the block adds three saturating counters:
//     cnt_mem_stall  cycles in which mem_wait is the winning action
//     cnt_loaduse    cycles in which load-use is the winning action
//     cnt_flush      cycles in which branch_taken is the winning action
//   When not defined, these ports and counters are absent.
//
// Ports:
//   clk, reset              Clock; asynchronous active-high reset.
//   id_rs, id_rt            Source registers of the instruction in ID.
//   ex_rs, ex_rt            Source registers of the instruction in EX.
//   ex_memread              The EX instruction is a load.
//   mem_regwrite, mem_dest  Regwrite flag and destination held in EX/MEM.
//   wb_regwrite, wb_dest    Regwrite flag and destination held in MEM/WB.
//   mem_req                 The MEM instruction accesses data memory.
//   dmem_ready              Data memory completes its access this cycle.
//   branch_taken            A branch/jump resolved as taken in EX.
//   stall_*                 Hold the PC or a pipeline register.
//   flush_ifid, flush_idex  Load a NOP into IF/ID or ID/EX.
//   bubble_memwb            Load a NOP into MEM/WB.
//   fwd_a, fwd_b            Forwarding selects:
//                             00 = register file
//                             10 = EX/MEM aluout
//                             01 = MEM/WB result
//   mem_busy                The FSM is waiting on data memory.
//   mem_error               Sticky timeout flag.
//   cnt_*                   Performance counters (PERF_COUNTERS_EN only).
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_dest,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_dest,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             bubble_memwb,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_busy,
  output logic             mem_error
`ifdef PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] cnt_mem_stall,
  output logic [CNT_W-1:0] cnt_loaduse,
  output logic [CNT_W-1:0] cnt_flush
`endif
);

  // ---------------------------------------------------------------------------
  // Local parameters and types
  // ---------------------------------------------------------------------------
  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

  // Forwarding select encodings.
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_e            state_q;
  state_e            state_d;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic [WCNT_W-1:0] wait_cnt_d;
  logic              mem_error_q;
  logic              mem_error_d;

  logic st_idle;
  logic st_wait;
  logic st_error;

  assign st_idle  = (state_q == ST_IDLE);
  assign st_wait  = (state_q == ST_WAIT);
  assign st_error = (state_q == ST_ERROR);

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic mem_wait;
  logic load_use;

  // The wait is visible in the same cycle the miss is first seen in IDLE.
  // When dmem_ready returns during WAIT, the freeze drops in that same cycle.
  assign mem_wait = (st_idle && mem_req && !dmem_ready)
                  || (st_wait && !dmem_ready)
                  || st_error;

  // A load writing $0 never creates a hazard.
  assign load_use = ex_memread && (ex_rt != 5'd0)
                  && ((ex_rt == id_rs) || (ex_rt == id_rt));

  // ---------------------------------------------------------------------------
  // Priority resolution
  // ---------------------------------------------------------------------------
  // Exactly one action (or none) wins in each cycle.
  logic act_mem;
  logic act_branch;
  logic act_loaduse;

  assign act_mem     = mem_wait;
  assign act_branch  = !mem_wait && branch_taken;
  assign act_loaduse = !mem_wait && !branch_taken && load_use;

  // mem_wait freezes the front of the pipe and drains a NOP into MEM/WB.
  // Load-use holds PC and IF/ID and injects one bubble through ID/EX.
  // Branch discards the two younger instructions.
  assign stall_pc     = act_mem || act_loaduse;
  assign stall_ifid   = act_mem || act_loaduse;
  assign stall_idex   = act_mem;
  assign stall_exmem  = act_mem;
  assign bubble_memwb = act_mem;
  assign flush_ifid   = act_branch;
  assign flush_idex   = act_branch || act_loaduse;

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  // Purely combinational, independent of the FSM.
  // The younger EX/MEM result takes precedence over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (wb_regwrite && (wb_dest != 5'd0) && (wb_dest == src))
      sel = FWD_MEMWB;
    if (mem_regwrite && (mem_dest != 5'd0) && (mem_dest == src))
      sel = FWD_EXMEM;
    return sel;
  endfunction

  assign fwd_a = fwd_sel(ex_rs);
  assign fwd_b = fwd_sel(ex_rt);

  // ---------------------------------------------------------------------------
  // Data-memory wait FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_req && !dmem_ready) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCNT_ONE;
        end
      end

      ST_WAIT: begin
        if (dmem_ready) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCNT_MAX) begin
          state_d     = ST_ERROR;
          mem_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_ONE;
        end
      end

      ST_ERROR: begin
        // Terminal until reset.
        mem_error_d = 1'b1;
      end

      default: begin
        state_d     = ST_ERROR;
        mem_error_d = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data-memory wait FSM: state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  // mem_busy follows the same release rule as the stalls: it reads low in
  // the cycle that dmem_ready arrives.
  assign mem_busy  = st_wait && !dmem_ready;
  assign mem_error = mem_error_q;

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] cnt_mem_stall_q;
  logic [CNT_W-1:0] cnt_loaduse_q;
  logic [CNT_W-1:0] cnt_flush_q;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_mem_stall_q <= '0;
      cnt_loaduse_q   <= '0;
      cnt_flush_q     <= '0;
    end else begin
      if (act_mem && (cnt_mem_stall_q != '1))
        cnt_mem_stall_q <= cnt_mem_stall_q + CNT_ONE;
      if (act_loaduse && (cnt_loaduse_q != '1))
        cnt_loaduse_q <= cnt_loaduse_q + CNT_ONE;
      if (act_branch && (cnt_flush_q != '1))
        cnt_flush_q <= cnt_flush_q + CNT_ONE;
    end
  end

  assign cnt_mem_stall = cnt_mem_stall_q;
  assign cnt_loaduse   = cnt_loaduse_q;
  assign cnt_flush     = cnt_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt;
  logic       ex_memread;
  logic       mem_regwrite;
  logic [4:0] mem_dest;
  logic       wb_regwrite;
  logic [4:0] wb_dest;
  logic       mem_req, dmem_ready, branch_taken;
  logic       stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic       flush_ifid, flush_idex, bubble_memwb;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_busy, mem_error;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cnt_mem_stall, cnt_loaduse, cnt_flush;
`endif

  int total = 0;
  int bad   = 0;

  // Control bundle, in this bit order:
  //   {stall_pc, stall_ifid, stall_idex, stall_exmem,
  //    flush_ifid, flush_idex, bubble_memwb}
  logic [6:0] ctl;
  assign ctl = {stall_pc, stall_ifid, stall_idex, stall_exmem,
                flush_ifid, flush_idex, bubble_memwb};

  localparam logic [6:0] CTL_NONE = 7'b0000000;
  localparam logic [6:0] CTL_MEM  = 7'b1111001;
  localparam logic [6:0] CTL_BR   = 7'b0000110;
  localparam logic [6:0] CTL_LU   = 7'b1100010;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_memread   (ex_memread),
    .mem_regwrite (mem_regwrite),
    .mem_dest     (mem_dest),
    .wb_regwrite  (wb_regwrite),
    .wb_dest      (wb_dest),
    .mem_req      (mem_req),
    .dmem_ready   (dmem_ready),
    .branch_taken (branch_taken),
    .stall_pc     (stall_pc),
    .stall_ifid   (stall_ifid),
    .stall_idex   (stall_idex),
    .stall_exmem  (stall_exmem),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .bubble_memwb (bubble_memwb),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .mem_busy     (mem_busy),
    .mem_error    (mem_error)
`ifdef PERF_COUNTERS_EN
    ,
    .cnt_mem_stall(cnt_mem_stall),
    .cnt_loaduse  (cnt_loaduse),
    .cnt_flush    (cnt_flush)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 2 time units after the next rising edge, away from the edge.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    id_rs        = '0;
    id_rt        = '0;
    ex_rs        = '0;
    ex_rt        = '0;
    ex_memread   = 1'b0;
    mem_regwrite = 1'b0;
    mem_dest     = '0;
    wb_regwrite  = 1'b0;
    wb_dest      = '0;
    mem_req      = 1'b0;
    dmem_ready   = 1'b0;
    branch_taken = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Reset state
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    #2;

    total++;
    if (ctl !== CTL_NONE) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_NONE);
    end

    total++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_fwd got=%b exp=0000", {fwd_a, fwd_b});
    end

    total++;
    if ({mem_busy, mem_error} !== 2'b00) begin
      bad++;
      $display("FAIL reset_status got=%b exp=00", {mem_busy, mem_error});
    end

`ifdef PERF_COUNTERS_EN
    total++;
    if ({cnt_mem_stall, cnt_loaduse, cnt_flush} !== 96'd0) begin
      bad++;
      $display("FAIL reset_counters nonzero");
    end
`endif

    // While held in reset (IDLE), hazard outputs are pure functions of inputs.
    ex_memread = 1'b1;
    ex_rt      = 5'd5;
    id_rs      = 5'd5;
    #1;
    total++;
    if (ctl !== CTL_LU) begin
      bad++;
      $display("FAIL reset_lu_comb got=%b exp=%b", ctl, CTL_LU);
    end

    clear_inputs();
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Load-use hazard
  // ---------------------------------------------------------------------------
  task automatic test_load_use();
    // Vector fields: {memread, ex_rt, id_rs, id_rt, hazard}
    logic [16:0] v [6];
    v[0] = {1'b1, 5'd5, 5'd5, 5'd0, 1'b1};
    v[1] = {1'b1, 5'd0, 5'd0, 5'd0, 1'b0};
    v[2] = {1'b1, 5'd5, 5'd1, 5'd5, 1'b1};
    v[3] = {1'b0, 5'd5, 5'd5, 5'd5, 1'b0};
    v[4] = {1'b1, 5'd7, 5'd5, 5'd6, 1'b0};
    v[5] = {1'b1, 5'd31, 5'd31, 5'd31, 1'b1};

    for (int i = 0; i < 6; i++) begin
      ex_memread = v[i][16];
      ex_rt      = v[i][15:11];
      id_rs      = v[i][10:6];
      id_rt      = v[i][5:1];
      #1;
      total++;
      if (ctl !== (v[i][0] ? CTL_LU : CTL_NONE)) begin
        bad++;
        $display("FAIL load_use[%0d] got=%b exp=%b",
                 i, ctl, (v[i][0] ? CTL_LU : CTL_NONE));
      end
      next_cycle();
    end

    // Once the hazard is gone the next cycle is clean.
    clear_inputs();
    #1;
    total++;
    if (ctl !== CTL_NONE) begin
      bad++;
      $display("FAIL load_use_release got=%b exp=%b", ctl, CTL_NONE);
    end
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  task automatic test_forwarding();
    // Vector fields: {mem_rw, mem_dest, wb_rw, wb_dest, ex_rs, ex_rt, fa, fb}
    logic [25:0] v [7];
    v[0] = {1'b1, 5'd3, 1'b1, 5'd3, 5'd3, 5'd0, 2'b10, 2'b00};
    v[1] = {1'b0, 5'd3, 1'b1, 5'd3, 5'd3, 5'd3, 2'b01, 2'b01};
    v[2] = {1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00};
    v[3] = {1'b1, 5'd4, 1'b1, 5'd7, 5'd7, 5'd4, 2'b01, 2'b10};
    v[4] = {1'b1, 5'd5, 1'b0, 5'd5, 5'd5, 5'd5, 2'b10, 2'b10};
    v[5] = {1'b0, 5'd5, 1'b1, 5'd5, 5'd6, 5'd2, 2'b00, 2'b00};
    v[6] = {1'b1, 5'd0, 1'b1, 5'd9, 5'd0, 5'd9, 2'b00, 2'b01};

    for (int i = 0; i < 7; i++) begin
      mem_regwrite = v[i][25];
      mem_dest     = v[i][24:20];
      wb_regwrite  = v[i][19];
      wb_dest      = v[i][18:14];
      ex_rs        = v[i][13:9];
      ex_rt        = v[i][8:4];
      #1;
      total++;
      if ({fwd_a, fwd_b} !== v[i][3:0]) begin
        bad++;
        $display("FAIL fwd[%0d] got a=%b b=%b exp a=%b b=%b",
                 i, fwd_a, fwd_b, v[i][3:2], v[i][1:0]);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Memory wait: ready low 3 cycles, then high
  // ---------------------------------------------------------------------------
  task automatic test_mem_wait();
    // Each step expects {ctl, mem_busy}.
    logic [7:0] exp [5];
    exp[0] = {CTL_MEM,  1'b0};   // IDLE, miss seen
    exp[1] = {CTL_MEM,  1'b1};   // WAIT
    exp[2] = {CTL_MEM,  1'b1};   // WAIT
    exp[3] = {CTL_NONE, 1'b0};   // WAIT, ready arrives -> released
    exp[4] = {CTL_NONE, 1'b0};   // back in IDLE

    for (int i = 0; i < 5; i++) begin
      mem_req    = (i < 4);
      dmem_ready = (i == 3);
      // Branch and load-use are asserted during WAIT and must be ignored.
      branch_taken = (i == 1);
      ex_memread   = (i == 2);
      ex_rt        = 5'd4;
      id_rs        = 5'd4;
      #1;
      total++;
      if ({ctl, mem_busy} !== exp[i]) begin
        bad++;
        $display("FAIL mem_wait[%0d] got ctl=%b busy=%b exp ctl=%b busy=%b",
                 i, ctl, mem_busy, exp[i][7:1], exp[i][0]);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Timeout into ERROR
  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    int busy_cycles;

    mem_req    = 1'b1;
    dmem_ready = 1'b0;
    next_cycle();  // now in WAIT with wait_cnt=1

    busy_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (mem_busy === 1'b1 && mem_error === 1'b0 && ctl === CTL_MEM)
        busy_cycles++;
      next_cycle();
    end

    total++;
    if (busy_cycles != 16) begin
      bad++;
      $display("FAIL timeout_wait_cycles got=%0d exp=16", busy_cycles);
    end

    total++;
    if ({mem_busy, mem_error, ctl} !== {1'b0, 1'b1, CTL_MEM}) begin
      bad++;
      $display("FAIL timeout_enter got busy=%b err=%b ctl=%b exp 0 1 %b",
               mem_busy, mem_error, ctl, CTL_MEM);
    end

    // ERROR is sticky even after the request goes away and ready returns.
    mem_req      = 1'b0;
    dmem_ready   = 1'b1;
    branch_taken = 1'b1;
    next_cycle();
    next_cycle();
    total++;
    if ({mem_error, ctl} !== {1'b1, CTL_MEM}) begin
      bad++;
      $display("FAIL timeout_sticky got err=%b ctl=%b exp 1 %b",
               mem_error, ctl, CTL_MEM);
    end

    // Asynchronous reset out of ERROR.
    clear_inputs();
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({mem_error, mem_busy, ctl} !== {2'b00, CTL_NONE}) begin
      bad++;
      $display("FAIL error_async_reset got err=%b busy=%b ctl=%b exp 0 0 %b",
               mem_error, mem_busy, ctl, CTL_NONE);
    end
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Branch priority
  // ---------------------------------------------------------------------------
  task automatic test_branch_priority();
    // Branch together with a load-use hazard: the branch wins.
    branch_taken = 1'b1;
    ex_memread   = 1'b1;
    ex_rt        = 5'd8;
    id_rt        = 5'd8;
    #1;
    total++;
    if (ctl !== CTL_BR) begin
      bad++;
      $display("FAIL branch_over_lu got=%b exp=%b", ctl, CTL_BR);
    end
    next_cycle();

    // Branch together with mem_wait: only the stalls are applied.
    mem_req    = 1'b1;
    dmem_ready = 1'b0;
    #1;
    total++;
    if (ctl !== CTL_MEM) begin
      bad++;
      $display("FAIL memwait_over_branch got=%b exp=%b", ctl, CTL_MEM);
    end
    next_cycle();

    // Ready arrives: released, so the branch now takes effect.
    dmem_ready = 1'b1;
    #1;
    total++;
    if (ctl !== CTL_BR) begin
      bad++;
      $display("FAIL branch_after_release got=%b exp=%b", ctl, CTL_BR);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Reset asserted mid-WAIT
  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_wait();
    mem_req    = 1'b1;
    dmem_ready = 1'b0;
    next_cycle();
    next_cycle();
    total++;
    if (mem_busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_wait_busy got=%b exp=1", mem_busy);
    end

    // Without reset, the WAIT state alone would keep the stalls up.
    #1;
    mem_req = 1'b0;
    reset   = 1'b1;
    #1;
    total++;
    if ({mem_busy, mem_error, ctl} !== {2'b00, CTL_NONE}) begin
      bad++;
      $display("FAIL mid_wait_reset got busy=%b err=%b ctl=%b exp 0 0 %b",
               mem_busy, mem_error, ctl, CTL_NONE);
    end

`ifdef PERF_COUNTERS_EN
    total++;
    if ({cnt_mem_stall, cnt_loaduse, cnt_flush} !== 96'd0) begin
      bad++;
      $display("FAIL mid_wait_counters nonzero");
    end
`endif

    next_cycle();
    reset = 1'b0;
    next_cycle();

    // After reset the FSM is in IDLE: no stall without a request.
    total++;
    if ({mem_busy, ctl} !== {1'b0, CTL_NONE}) begin
      bad++;
      $display("FAIL post_reset_idle got busy=%b ctl=%b", mem_busy, ctl);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_mem_wait();
    test_timeout();
    test_branch_priority();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
